// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: ALU ops, opcodes, operand/result/immediate selects.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // Which family of ALU decode the current control state needs.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'b00,
    CLS_EXEC   = 2'b01,
    CLS_BRANCH = 2'b10
  } alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_control_if.sv
// Control <-> datapath/memory bundle: IR fields and ALU flags in, selects and enables out.
// Latency: n/a (wiring only). Optional port illegal_instr exists under RV32I_ILLEGAL_TRAP_EN.
// Backpressure: memory stalls the controller through mem_ready.
interface rv32i_mc_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       last_bit;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       instr_done;
`ifdef RV32I_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  op, funct3, funct7b5, zero, last_bit, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, instr_done
`ifdef RV32I_ILLEGAL_TRAP_EN
           , illegal_instr
`endif
  );

  modport slave (
    output op, funct3, funct7b5, zero, last_bit, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, instr_done
`ifdef RV32I_ILLEGAL_TRAP_EN
           , illegal_instr
`endif
  );
endinterface

// File: rtl/rv32i_alu_decoder.sv
// Maps (op, funct3, funct7b5, state class) to the ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module rv32i_alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  alu_class_e alu_class,
  output alu_op_e    alu_control
);

  logic is_rtype;
  assign is_rtype = (op == OP_RTYPE);

  // funct7b5 only selects SUB for register-register ops; immediates carry imm bits there.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_EXEC: begin
        case (funct3)
          3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_control = ALU_SUB;
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control FSM; optional illegal-opcode trap under RV32I_ILLEGAL_TRAP_EN.
// Latency: branch 3, ALU/store/JAL/LUI/AUIPC 4, load/JALR 5 cycles, plus memory stalls.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; reset drops enables at once.
module rv32i_mc_control
  import rv32i_pkg::*;
#(
  // Encoding of the reset state; S_FETCH is encoded as 0.
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic               clk,
  input logic               rst,
  rv32i_mc_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2,
    S_LUI, S_AUIPC, S_TRAP
  } state_e;

  state_e     state, state_n;
  alu_class_e alu_class;
  alu_op_e    alu_op;
  logic       taken;

  rv32i_alu_decoder u_alu_dec (
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_class   (alu_class),
    .alu_control (alu_op)
  );

  // State register; an instruction interrupted by reset is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) state <= state_e'(RESET_STATE);
    else     state <= state_n;
  end

  // Next state and control outputs: defaults first, each state overrides what differs.
  always_comb begin
    state_n        = state;
    alu_class      = CLS_ADD;
    taken          = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_n      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/JAL target into ALUOut while decoding.
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECR;
          OP_ITYPE:          state_n = S_EXECI;
          OP_BRANCH:         state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           state_n = S_JALR;
          OP_LUI:            state_n = S_LUI;
          OP_AUIPC:          state_n = S_AUIPC;
          default: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
            state_n = S_TRAP;
`else
            bus.instr_done = 1'b1;
            state_n        = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        state_n       = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
        if (bus.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_RDATA;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_n        = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_n        = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_class     = CLS_EXEC;
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        state_n       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_n        = S_FETCH;
      end
      S_BRANCH: begin
        alu_class      = CLS_BRANCH;
        bus.alu_src_a  = SRCA_RS1;
        bus.instr_done = 1'b1;
        case (bus.funct3)
          3'b000:         taken = bus.zero;
          3'b001:         taken = ~bus.zero;
          3'b100, 3'b110: taken = bus.last_bit;
          3'b101, 3'b111: taken = ~bus.last_bit;
          default:        taken = 1'b0;
        endcase
        bus.pc_write = taken;
        state_n      = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC takes the target held in ALUOut while the ALU forms the link address.
        bus.pc_write  = 1'b1;
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        state_n       = S_ALUWB;
      end
      S_JALR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        state_n       = S_JALR2;
      end
      S_LUI: begin
        bus.alu_src_a = SRCA_ZERO;
        bus.alu_src_b = SRCB_IMM;
        state_n       = S_ALUWB;
      end
      S_AUIPC: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        state_n       = S_ALUWB;
      end
`ifdef RV32I_ILLEGAL_TRAP_EN
      S_TRAP: state_n = S_TRAP;
`endif
      default: state_n = S_FETCH;
    endcase
    // Reset kills every enable in the same cycle so an in-flight write never lands.
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.instr_done = 1'b0;
    end
  end

  assign bus.alu_control = alu_op;
  assign bus.imm_src     = imm_src_of(bus.op);
`ifdef RV32I_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Randomized bench for rv32i_mc_control against a per-instruction micro-step plan.
// Latency: checks every cycle of each instruction and the cycle of instr_done.
// Backpressure: drives mem_ready stalls in fetch and memory phases; RV32I_ILLEGAL_TRAP_EN aware.
module tb_rv32i_mc_control;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst;
  rv32i_mc_control_if bus ();

  rv32i_mc_control #(.RESET_STATE(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, irw, rw, mr, mw, adr;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic done;
  } ctl_t;

  typedef struct packed {
    logic waits;
    ctl_t base;
    ctl_t extra;
  } phase_t;

  phase_t plan[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t t;
    t.pcw = bus.pc_write;   t.irw = bus.ir_write;  t.rw = bus.reg_write;
    t.mr = bus.mem_read;    t.mw = bus.mem_write;  t.adr = bus.adr_src;
    t.rs = bus.result_src;  t.a = bus.alu_src_a;   t.b = bus.alu_src_b;
    t.imm = bus.imm_src;    t.alu = bus.alu_control; t.done = bus.instr_done;
    return t;
  endfunction

  // en = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src}
  function automatic ctl_t mk(input logic [5:0] en, input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [3:0] alu, input logic done);
    ctl_t t;
    {t.pcw, t.irw, t.rw, t.mr, t.mw, t.adr} = en;
    t.rs = rs; t.a = a; t.b = b; t.imm = 3'b000; t.alu = alu; t.done = done;
    return t;
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic known(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Mnemonic-level ALU op for OP / OP-IMM instructions.
  function automatic logic [3:0] exec_alu(input logic rtype, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (rtype && f7) ? 4'b0001 : 4'b0000;  // SUB / ADD(I)
      3'd1: return 4'b0101;                             // SLL(I)
      3'd2: return 4'b1000;                             // SLT(I)
      3'd3: return 4'b1001;                             // SLTU / SLTIU
      3'd4: return 4'b0100;                             // XOR(I)
      3'd5: return f7 ? 4'b0111 : 4'b0110;              // SRA(I) / SRL(I)
      3'd6: return 4'b0011;                             // OR(I)
      default: return 4'b0010;                          // AND(I)
    endcase
  endfunction

  function automatic int lat_ref(input logic [6:0] op);
    case (op)
      7'b1100011: return 3;
      7'b0000011, 7'b1100111: return 5;
      7'b0110011, 7'b0010011, 7'b0100011, 7'b1101111, 7'b0110111, 7'b0010111: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic add(input logic waits, input ctl_t base, input ctl_t extra);
    phase_t p;
    p.waits = waits; p.base = base; p.extra = extra;
    plan.push_back(p);
  endtask

  // Micro-step plan of one instruction as the ISA-level sequence of datapath actions.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lb);
    logic [3:0] balu;
    logic       tk;
    ctl_t       none;
    ctl_t       wb;
    none = '0;
    wb   = mk(6'b001000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1);
    plan.delete();
    add(1'b1, mk(6'b000100, 2'b10, 2'b00, 2'b10, 4'h0, 1'b0), mk(6'b110000, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0));
    add(1'b0, mk(6'b000000, 2'b00, 2'b01, 2'b01, 4'h0, !known(op)), none);
    case (op)
      7'b0000011: begin
        add(1'b0, mk(6'b000000, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0), none);
        add(1'b1, mk(6'b000101, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0), none);
        add(1'b0, mk(6'b001000, 2'b01, 2'b00, 2'b00, 4'h0, 1'b1), none);
      end
      7'b0100011: begin
        add(1'b0, mk(6'b000000, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0), none);
        add(1'b1, mk(6'b000011, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0), mk(6'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1));
      end
      7'b0110011: begin
        add(1'b0, mk(6'b0, 2'b00, 2'b10, 2'b00, exec_alu(1'b1, f3, f7), 1'b0), none);
        add(1'b0, wb, none);
      end
      7'b0010011: begin
        add(1'b0, mk(6'b0, 2'b00, 2'b10, 2'b01, exec_alu(1'b0, f3, f7), 1'b0), none);
        add(1'b0, wb, none);
      end
      7'b1100011: begin
        case (f3)
          3'd0: begin balu = 4'b0001; tk = z;   end
          3'd1: begin balu = 4'b0001; tk = !z;  end
          3'd4: begin balu = 4'b1000; tk = lb;  end
          3'd5: begin balu = 4'b1000; tk = !lb; end
          3'd6: begin balu = 4'b1001; tk = lb;  end
          3'd7: begin balu = 4'b1001; tk = !lb; end
          default: begin balu = 4'b0000; tk = 1'b0; end
        endcase
        add(1'b0, mk({tk, 5'b00000}, 2'b00, 2'b10, 2'b00, balu, 1'b1), none);
      end
      7'b1101111: begin
        add(1'b0, mk(6'b100000, 2'b00, 2'b01, 2'b10, 4'h0, 1'b0), none);
        add(1'b0, wb, none);
      end
      7'b1100111: begin
        add(1'b0, mk(6'b000000, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0), none);
        add(1'b0, mk(6'b100000, 2'b00, 2'b01, 2'b10, 4'h0, 1'b0), none);
        add(1'b0, wb, none);
      end
      7'b0110111: begin
        add(1'b0, mk(6'b0, 2'b00, 2'b11, 2'b01, 4'h0, 1'b0), none);
        add(1'b0, wb, none);
      end
      7'b0010111: begin
        add(1'b0, mk(6'b0, 2'b00, 2'b01, 2'b01, 4'h0, 1'b0), none);
        add(1'b0, wb, none);
      end
      default: ;
    endcase
  endtask

  // Runs one instruction from a FETCH-state negedge; fstall/mstall are mem_ready-low cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic lb, input int fstall, input int mstall);
    int   cyc;
    int   done_at;
    int   n_done;
    int   stalls;
    ctl_t e;
    ctl_t o;
    cyc = 0; done_at = -1; n_done = 0;
    build(op, f3, f7, z, lb);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z; bus.last_bit = lb;
    for (int i = 0; i < plan.size(); i++) begin
      stalls = (i == 0) ? fstall : (plan[i].waits ? mstall : 0);
      for (int s = 0; s <= stalls; s++) begin
        if (plan[i].waits) bus.mem_ready = (s == stalls);
        else               bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        e = (plan[i].waits && s == stalls) ? (plan[i].base | plan[i].extra) : plan[i].base;
        e.imm = imm_ref(op);
        o = obs();
        chk($sformatf("ctl op=%07b f3=%0d step=%0d stall=%0d", op, f3, i, s), 32'(o), 32'(e));
        cyc++;
        if (o.done) begin
          n_done++;
          if (done_at < 0) done_at = cyc;
        end
        @(negedge clk);
      end
    end
    chk($sformatf("latency op=%07b", op), 32'(done_at),
        32'(lat_ref(op) + fstall + ((op == 7'b0000011 || op == 7'b0100011) ? mstall : 0)));
    chk($sformatf("done_pulses op=%07b", op), 32'(n_done), 32'd1);
  endtask

  logic [6:0] ops [10];
  ctl_t       fe;
  logic [6:0] rop;
  int         nops;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    rst = 1'b1;
    bus.op = 7'b0110011; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.last_bit = 1'b0; bus.mem_ready = 1'b1;

    // Reset: enables forced low even with mem_ready high.
    @(negedge clk); #1;
    chk("rst_enables", 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                            bus.mem_write, bus.instr_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0; #1;
    fe = mk(6'b000100, 2'b10, 2'b00, 2'b10, 4'h0, 1'b0);
    chk("reset_state_fetch", 32'(obs()), 32'(fe));
    @(negedge clk);

    // Directed cases.
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // ADD
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // SUB
    run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);  // SRAI
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // ADDI with imm bit 30 set
    run_instr(7'b1100011, 3'd6, 1'b0, 1'b0, 1'b1, 0, 0);  // BLTU taken
    run_instr(7'b1100011, 3'd6, 1'b0, 1'b0, 1'b0, 0, 0);  // BLTU not taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);  // BNE with zero
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);  // LW with 3 stalls -> 8 cycles
    run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);  // JALR with fetch stall

    // Reset during a stalled store.
    bus.op = 7'b0100011; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    bus.mem_ready = 1'b0; #1;
    chk("sw_wait_mem_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1; bus.mem_ready = 1'b1; #1;
    chk("sw_rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("sw_rst_instr_done", 32'(bus.instr_done), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0; #1;
    fe.imm = 3'b001;
    chk("sw_rst_fetch", 32'(obs()), 32'(fe));
    @(negedge clk);

`ifdef RV32I_ILLEGAL_TRAP_EN
    // Unknown opcode traps until reset.
    bus.op = 7'b0000000; bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("trap_decode", 32'(obs()), 32'(mk(6'b0, 2'b00, 2'b01, 2'b01, 4'h0, 1'b0)));
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("trap_illegal", 32'(bus.illegal_instr), 32'd1);
      chk("trap_outputs", 32'(obs()), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0; #1;
    chk("trap_cleared", 32'(bus.illegal_instr), 32'd0);
    @(negedge clk);
    nops = 9;
`else
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);  // unknown opcode as NOP
    nops = 10;
`endif

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      rop = ops[$urandom_range(0, nops - 1)];
      run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
